// File: rtl/cache_mem_arbiter.sv
// Shared main-memory port arbiter between the instruction cache and the data cache.
// Data requests win, but a saturating counter bounds how long an instruction fetch can starve.
module cache_mem_arbiter #(
  parameter int DMAX = 4
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] i_a,
  input  logic        i_access,
  output logic [31:0] i_d_r,
  output logic        i_ready,
  input  logic [31:0] d_a,
  input  logic [31:0] d_d_w,
  input  logic        d_access,
  input  logic        d_write,
  output logic [31:0] d_d_r,
  output logic        d_ready,
  output logic [31:0] m_a,
  output logic [31:0] m_d_w,
  output logic        m_access,
  output logic        m_write,
  input  logic [31:0] m_d_r,
  input  logic        m_ready,
  output logic        gnt_i,
  output logic        gnt_d
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  localparam logic [3:0] DMAX_C = 4'(DMAX);

  state_t     state;
  logic [3:0] dcnt;

  // A dropped request aborts the grant without touching dcnt; every grant returns to IDLE.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
      dcnt  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (d_access && (!i_access || dcnt < DMAX_C))
            state <= GNT_D;
          else if (i_access)
            state <= GNT_I;
        end
        GNT_D: begin
          if (!d_access) begin
            state <= IDLE;
          end else if (m_ready) begin
            state <= IDLE;
            if (!i_access)
              dcnt <= 4'd0;
            else if (dcnt >= DMAX_C)
              dcnt <= DMAX_C;
            else
              dcnt <= dcnt + 4'd1;
          end
        end
        GNT_I: begin
          if (!i_access) begin
            state <= IDLE;
          end else if (m_ready) begin
            state <= IDLE;
            dcnt  <= 4'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign i_d_r = m_d_r;
  assign d_d_r = m_d_r;
  assign gnt_i = (state == GNT_I);
  assign gnt_d = (state == GNT_D);

  always_comb begin
    m_a      = 32'd0;
    m_d_w    = 32'd0;
    m_access = 1'b0;
    m_write  = 1'b0;
    i_ready  = 1'b0;
    d_ready  = 1'b0;
    case (state)
      GNT_D: begin
        m_a      = d_a;
        m_d_w    = d_d_w;
        m_write  = d_write;
        m_access = d_access;
        d_ready  = m_ready & d_access;
      end
      GNT_I: begin
        m_a      = i_a;
        m_access = i_access;
        i_ready  = m_ready & i_access;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a DMAX=4 instance and a DMAX=2 instance
// share all inputs, so the grant-order runs check both starvation bounds at once.
module tb_cache_mem_arbiter;

  logic        clk = 1'b0;
  logic        clrn;
  logic [31:0] i_a, d_a, d_d_w, m_d_r;
  logic        i_access, d_access, d_write, m_ready;

  logic [31:0] i_d_r, d_d_r, m_a, m_d_w;
  logic        i_ready, d_ready, m_access, m_write, gnt_i, gnt_d;
  logic [31:0] i_d_r_2, d_d_r_2, m_a_2, m_d_w_2;
  logic        i_ready_2, d_ready_2, m_access_2, m_write_2, gnt_i_2, gnt_d_2;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.DMAX(4)) u_dut1 (
    .clk(clk), .clrn(clrn),
    .i_a(i_a), .i_access(i_access), .i_d_r(i_d_r), .i_ready(i_ready),
    .d_a(d_a), .d_d_w(d_d_w), .d_access(d_access), .d_write(d_write),
    .d_d_r(d_d_r), .d_ready(d_ready),
    .m_a(m_a), .m_d_w(m_d_w), .m_access(m_access), .m_write(m_write),
    .m_d_r(m_d_r), .m_ready(m_ready),
    .gnt_i(gnt_i), .gnt_d(gnt_d)
  );

  cache_mem_arbiter #(.DMAX(2)) u_dut2 (
    .clk(clk), .clrn(clrn),
    .i_a(i_a), .i_access(i_access), .i_d_r(i_d_r_2), .i_ready(i_ready_2),
    .d_a(d_a), .d_d_w(d_d_w), .d_access(d_access), .d_write(d_write),
    .d_d_r(d_d_r_2), .d_ready(d_ready_2),
    .m_a(m_a_2), .m_d_w(m_d_w_2), .m_access(m_access_2), .m_write(m_write_2),
    .m_d_r(m_d_r), .m_ready(m_ready),
    .gnt_i(gnt_i_2), .gnt_d(gnt_d_2)
  );

  task automatic check_bit(input string tag, input logic observed, input logic expected);
    assert_cnt++;
    assert (observed === expected) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic check_word(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_cnt++;
    assert (observed === expected) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Grant patterns with both requests and m_ready held high: 1 = instruction grant.
  logic exp1_is_i [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic exp2_is_i [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    clrn = 1'b0; i_a = 32'd0; d_a = 32'd0; d_d_w = 32'd0; m_d_r = 32'h1234_5678;
    i_access = 1'b0; d_access = 1'b0; d_write = 1'b0; m_ready = 1'b0;

    tick;
    check_bit("rst_gnt_i", gnt_i, 1'b0);
    check_bit("rst_gnt_d", gnt_d, 1'b0);
    check_bit("rst_m_access", m_access, 1'b0);
    check_word("rst_m_a", m_a, 32'd0);
    check_word("rst_dcnt", 32'(u_dut1.dcnt), 32'd0);
    clrn = 1'b1;

    // Lone instruction fetch, memory answers on the third grant cycle
    i_access = 1'b1; i_a = 32'h0000_0148;
    check_bit("if_idle_m_access", m_access, 1'b0);
    tick;
    check_bit("if_gnt_i", gnt_i, 1'b1);
    check_word("if_m_a", m_a, 32'h0000_0148);
    check_bit("if_m_write", m_write, 1'b0);
    check_bit("if_m_access", m_access, 1'b1);
    check_bit("if_i_ready_early", i_ready, 1'b0);
    tick;
    tick;
    check_bit("if_still_gnt", gnt_i, 1'b1);
    m_ready = 1'b1;
    #1;
    check_bit("if_i_ready", i_ready, 1'b1);
    check_word("if_i_d_r", i_d_r, 32'h1234_5678);
    check_bit("if_d_ready", d_ready, 1'b0);
    tick;
    i_access = 1'b0; m_ready = 1'b0;
    #1;
    check_bit("if_idle_gnt_i", gnt_i, 1'b0);
    check_bit("if_idle_i_ready", i_ready, 1'b0);

    // Data write
    d_access = 1'b1; d_write = 1'b1; d_a = 32'h0000_0200; d_d_w = 32'hDEAD_BEEF;
    tick;
    check_bit("dw_gnt_d", gnt_d, 1'b1);
    check_word("dw_m_a", m_a, 32'h0000_0200);
    check_word("dw_m_d_w", m_d_w, 32'hDEAD_BEEF);
    check_bit("dw_m_write", m_write, 1'b1);
    check_bit("dw_d_ready_early", d_ready, 1'b0);
    m_ready = 1'b1; m_d_r = 32'hCAFE_0001;
    #1;
    check_bit("dw_d_ready", d_ready, 1'b1);
    check_bit("dw_i_ready", i_ready, 1'b0);
    check_word("dw_d_d_r", d_d_r, 32'hCAFE_0001);
    tick;
    m_ready = 1'b0;
    #1;
    check_bit("dw_idle", gnt_d, 1'b0);

    // Reset in the middle of a data transaction (d_access still high)
    tick;
    check_bit("rm_gnt_d", gnt_d, 1'b1);
    clrn = 1'b0;
    #1;
    check_bit("rm_m_access", m_access, 1'b0);
    check_bit("rm_m_write", m_write, 1'b0);
    check_bit("rm_d_ready", d_ready, 1'b0);
    check_bit("rm_gnt_d_low", gnt_d, 1'b0);
    clrn = 1'b1;
    tick;
    check_bit("rm_regrant_d", gnt_d, 1'b1);
    d_access = 1'b0; d_write = 1'b0;
    #1;
    check_bit("dabort_m_access", m_access, 1'b0);
    tick;
    check_bit("dabort_idle", gnt_d, 1'b0);

    // Make dcnt=1, then abort an instruction grant on its second cycle
    i_access = 1'b1; d_access = 1'b1;
    tick;
    check_bit("ab_pre_gnt_d", gnt_d, 1'b1);
    m_ready = 1'b1;
    tick;
    d_access = 1'b0; m_ready = 1'b0;
    check_word("ab_pre_dcnt", 32'(u_dut1.dcnt), 32'd1);
    tick;
    check_bit("ab_gnt_i", gnt_i, 1'b1);
    tick;
    i_access = 1'b0;
    #1;
    check_bit("ab_m_access", m_access, 1'b0);
    check_bit("ab_i_ready", i_ready, 1'b0);
    tick;
    check_bit("ab_idle", gnt_i, 1'b0);
    check_word("ab_dcnt", 32'(u_dut1.dcnt), 32'd1);

    // Starvation bound: DMAX=4 gives D,D,D,D,I,D; DMAX=2 gives D,D,I,D,D,I
    clrn = 1'b0;
    tick;
    clrn = 1'b1;
    i_access = 1'b1; d_access = 1'b1; d_write = 1'b0; m_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick;
      check_bit($sformatf("ord1_i_%0d", k), gnt_i, exp1_is_i[k]);
      check_bit($sformatf("ord1_d_%0d", k), gnt_d, ~exp1_is_i[k]);
      check_bit($sformatf("ord2_i_%0d", k), gnt_i_2, exp2_is_i[k]);
      check_bit($sformatf("ord2_d_%0d", k), gnt_d_2, ~exp2_is_i[k]);
      check_bit($sformatf("excl2_%0d", k), gnt_i_2 & gnt_d_2, 1'b0);
      tick;
      check_bit($sformatf("gap1_%0d", k), gnt_i | gnt_d, 1'b0);
      check_bit($sformatf("gap2_%0d", k), gnt_i_2 | gnt_d_2, 1'b0);
      if (k == 4)
        check_word("ord1_dcnt_after_i", 32'(u_dut1.dcnt), 32'd0);
    end
    check_word("ord1_dcnt_end", 32'(u_dut1.dcnt), 32'd1);
    check_word("ord2_dcnt_end", 32'(u_dut2.dcnt), 32'd0);

    i_access = 1'b0; d_access = 1'b0; m_ready = 1'b0;
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
